// File: rtl/accum.sv
// accum: streaming signed multiply-accumulate with floor rescale and saturation for the LSTM datapath
module accum #(
  parameter int DWIDTH   = 16,
  parameter int FRAC     = 8,
  parameter int LWIDTH   = 10,
  parameter int ACCWIDTH = 42
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [LWIDTH-1:0] len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_x,
  input  logic [DWIDTH-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_sum,
  output logic              out_ovf,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACC, FLUSH, OUT} state_t;
  state_t                r_state;
  logic [LWIDTH-1:0]     r_len;
  logic [LWIDTH-1:0]     r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [2*DWIDTH-1:0]   r_prod;
  logic                  r_pv;
  logic [ACCWIDTH-1:0]   r_acc;
  logic                  w_hs;
  logic [LWIDTH-1:0]     w_cnt_nxt;
  logic [2*DWIDTH-1:0]   w_x;
  logic [2*DWIDTH-1:0]   w_w;
  logic [2*DWIDTH-1:0]   w_prod;
  logic [ACCWIDTH-1:0]   w_prod_ext;
  logic [ACCWIDTH-1:0]   w_shift;
  logic                  w_fits;
  logic [DWIDTH-1:0]     w_sat;
  assign w_hs       = in_valid && r_in_ready;
  assign w_cnt_nxt  = r_cnt + 1'b1;
  // Operands sign-extended to full product width so the low 2*DWIDTH bits are the signed product.
  assign w_x        = {{DWIDTH{in_x[DWIDTH-1]}}, in_x};
  assign w_w        = {{DWIDTH{in_w[DWIDTH-1]}}, in_w};
  assign w_prod     = w_x * w_w;
  assign w_prod_ext = {{(ACCWIDTH-2*DWIDTH){r_prod[2*DWIDTH-1]}}, r_prod};
  assign w_shift    = $signed(r_acc) >>> FRAC;
  // The shifted sum fits when every bit above the result's sign bit matches it.
  assign w_fits     = (&w_shift[ACCWIDTH-1:DWIDTH-1]) | ~(|w_shift[ACCWIDTH-1:DWIDTH-1]);
  assign w_sat      = w_fits ? w_shift[DWIDTH-1:0]
                             : {w_shift[ACCWIDTH-1], {(DWIDTH-1){~w_shift[ACCWIDTH-1]}}};
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign out_sum    = r_out_valid ? w_sat : '0;
  assign out_ovf    = r_out_valid & ~w_fits;
  // Control FSM: term counting and registered handshake/status outputs.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_len       <= len;
          r_cnt       <= '0;
          r_busy      <= 1'b1;
          r_state     <= (len == '0) ? OUT : ACC;
          r_in_ready  <= (len != '0);
          r_out_valid <= (len == '0);
        end
        ACC: if (w_hs) begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len) begin
            r_state    <= FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          r_state     <= OUT;
          r_out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Datapath: product register, then accumulate one cycle later; a honoured start clears the sum.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_pv <= w_hs;
      if (w_hs) r_prod <= w_prod;
      r_acc <= (r_state == IDLE && start) ? '0 : r_pv ? r_acc + w_prod_ext : r_acc;
    end
  end
endmodule

// File: tb/tb_accum.sv
// tb_accum: randomized and directed checks of accum against a behavioural dot-product model
module tb_accum;
  localparam int DW = 16, FR = 8, LW = 10, AW = 42;
  logic          clk = 1'b0, xrst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] in_x = '0, in_w = '0;
  logic          in_ready, out_valid, out_ovf, busy;
  logic [DW-1:0] out_sum;
  int            checks = 0, errors = 0;
  logic [DW-1:0] tx [0:1023];
  logic [DW-1:0] tw [0:1023];
  logic [DW-1:0] res_sum;
  logic          res_ovf;
  int            res_lat, hs_total;

  always #5 clk = ~clk;

  accum #(.DWIDTH(DW), .FRAC(FR), .LWIDTH(LW), .ACCWIDTH(AW)) dut (
    .clk(clk), .xrst(xrst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected {ovf, sum} from an exact integer dot product.
  function automatic logic [DW:0] expect_out(input longint s);
    longint q;
    q = s >>> FR;
    if (q > 32767)  return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[DW-1:0]};
  endfunction

  typedef enum {M_IDLE, M_ACC, M_FLUSH, M_OUT} mph_t;
  mph_t   mph = M_IDLE;
  int     mlen = 0, mcnt = 0;
  longint msum = 0;

  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      mph  <= M_IDLE;
      mcnt <= 0;
      msum <= 0;
    end else begin
      case (mph)
        M_IDLE: if (start) begin
          mlen <= int'(len);
          mcnt <= 0;
          msum <= 0;
          mph  <= (len == 0) ? M_OUT : M_ACC;
        end
        M_ACC: if (in_valid) begin
          msum <= msum + longint'($signed(in_x)) * longint'($signed(in_w));
          mcnt <= mcnt + 1;
          if (mcnt + 1 == mlen) mph <= M_FLUSH;
        end
        M_FLUSH: mph <= M_OUT;
        M_OUT: if (out_ready) mph <= M_IDLE;
      endcase
    end
  end

  logic [DW:0] e;
  always @(negedge clk) begin
    if (xrst) begin
      chk("in_ready", in_ready, mph == M_ACC);
      chk("out_valid", out_valid, mph == M_OUT);
      chk("busy", busy, mph != M_IDLE);
      if (mph == M_OUT) begin
        e = expect_out(msum);
        chk("out_sum", $signed(out_sum), $signed(e[DW-1:0]));
        chk("out_ovf", out_ovf, e[DW]);
      end
    end
  end

  // One dot product starting at the current negedge; ends at the negedge after the result handshake.
  task automatic run_op(input int n, input bit tog, input int hold, input bit noisy);
    int i, cyc, lat;
    bit hs;
    logic [DW-1:0] s0;
    start = 1'b1; len = LW'(n); in_valid = noisy; in_x = 16'h7fff; in_w = 16'h7fff;
    @(negedge clk);
    start = 1'b0;
    i = 0; cyc = 0; hs_total = 0;
    while (i < n && cyc < 4 * n + 20) begin
      in_valid = tog ? ~cyc[0] : 1'b1;
      in_x = tx[i]; in_w = tw[i];
      hs = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) begin i++; hs_total++; end
    end
    in_valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    res_lat = lat; res_sum = out_sum; res_ovf = out_ovf; s0 = out_sum;
    for (int h = 0; h < hold; h++) begin
      start = noisy & ~h[0]; len = LW'(3);
      @(negedge clk);
      chk("hold_sum", out_sum, s0);
      chk("hold_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1; start = noisy; len = LW'(5);
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    xrst = 1'b1;
    @(negedge clk);
    // basic sum
    tx[0] = 16'sd256;  tw[0] = 16'sd256;
    tx[1] = 16'sd512;  tw[1] = 16'sd256;
    tx[2] = -16'sd256; tw[2] = 16'sd256;
    run_op(3, 1'b0, 0, 1'b0);
    chk("basic_sum", $signed(res_sum), 512);
    chk("basic_ovf", res_ovf, 0);
    chk("basic_lat", res_lat, 2);
    // positive saturation
    tx[0] = 16'sd32767; tw[0] = 16'sd32767; tx[1] = 16'sd32767; tw[1] = 16'sd32767;
    run_op(2, 1'b0, 0, 1'b0);
    chk("satp_sum", $signed(res_sum), 32767);
    chk("satp_ovf", res_ovf, 1);
    // negative saturation
    tx[0] = 16'h8000; tw[0] = 16'sd32767;
    run_op(1, 1'b0, 0, 1'b0);
    chk("satn_sum", $signed(res_sum), -32768);
    chk("satn_ovf", res_ovf, 1);
    // floor rounding
    tx[0] = -16'sd1; tw[0] = 16'sd1;
    run_op(1, 1'b0, 0, 1'b0);
    chk("floor_neg_sum", $signed(res_sum), -1);
    chk("floor_neg_ovf", res_ovf, 0);
    tx[0] = 16'sd1; tw[0] = 16'sd255;
    run_op(1, 1'b0, 0, 1'b0);
    chk("floor_pos_sum", $signed(res_sum), 0);
    // backpressure: toggled in_valid, held result, ignored start pulses
    for (int k = 0; k < 4; k++) begin tx[k] = 16'(k * 100 + 7); tw[k] = 16'sd300; end
    run_op(4, 1'b1, 5, 1'b1);
    chk("bp_accepted", hs_total, 4);
    chk("bp_sum", $signed(res_sum), (107 + 207 + 307 + 7) * 300 / 256);
    // zero length then immediate start
    run_op(0, 1'b0, 0, 1'b0);
    chk("zero_lat", res_lat, 1);
    chk("zero_sum", $signed(res_sum), 0);
    chk("zero_ovf", res_ovf, 0);
    tx[0] = 16'sd256; tw[0] = 16'sd256;
    run_op(1, 1'b0, 0, 1'b0);
    chk("b2b_sum", $signed(res_sum), 256);
    // reset in the middle of accumulation
    begin
      int k, g;
      bit hs;
      start = 1'b1; len = LW'(4);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_x = 16'sd1000; in_w = 16'sd1000;
      k = 0; g = 0;
      while (k < 2 && g < 20) begin hs = in_ready; @(negedge clk); g++; if (hs) k++; end
      chk("mid_pairs", k, 2);
      #2 xrst = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_sum", out_sum, 0);
      chk("arst_out_ovf", out_ovf, 0);
      chk("arst_busy", busy, 0);
      in_valid = 1'b0;
      @(negedge clk);
      xrst = 1'b1;
    end
    tx[0] = 16'sd256; tw[0] = 16'sd256; tx[1] = 16'sd256; tw[1] = 16'sd256;
    run_op(2, 1'b0, 0, 1'b0);
    chk("post_rst_sum", $signed(res_sum), 512);
    chk("post_rst_ovf", res_ovf, 0);
    // maximum length of full-scale products
    for (int k = 0; k < 1023; k++) begin tx[k] = 16'h8000; tw[k] = 16'h8000; end
    run_op(1023, 1'b0, 0, 1'b0);
    chk("maxlen_sum", $signed(res_sum), 32767);
    chk("maxlen_ovf", res_ovf, 1);
    // randomized operations, checked every cycle by the model
    for (int r = 0; r < 40; r++) begin
      int n, mode;
      n = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if (mode == 0) begin
          tx[k] = 16'($signed(11'($urandom))); tw[k] = 16'($signed(11'($urandom)));
        end else if (mode == 1) begin
          tx[k] = 16'($urandom); tw[k] = 16'($urandom);
        end else begin
          tx[k] = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
          tw[k] = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
        end
      end
      run_op(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
